reg_port_master: RTL and testbench
==================================

// Module: reg_port_master
// PURPOSE
// - Initiator for the 32x32 register/data-memory control port (sel / read_write / enable / data_in / data_out).
// - Accepts single writes and burst reads on a valid/ready request interface.
// - Sequences the strobes to the memory and returns read data on a response channel.
// - Replaces hand-driven testbench stimulus; sits between the CPU control path and the memory control block.
// PARAMETERS
// - DATA_W  32  data width of rf_data_in / rf_data_out / req_wdata / rsp_rdata
// - ADDR_W  5   address (sel) width; depth = 2**ADDR_W
// - RD_LAT  1   cycles from read strobe to valid rf_data_out; legal range 0..7
// PORTS
// - clk            in   1       single clock; all logic on posedge
// - rst            in   1       synchronous, active-high reset
// - req_valid      in   1       request present
// - req_ready      out  1       block can accept; high only in IDLE
// - req_write      in   1       1 = write, 0 = read burst
// - req_addr       in   ADDR_W  start address
// - req_len        in   ADDR_W  read beats minus 1; ignored for writes
// - req_wdata      in   DATA_W  write data
// - rsp_valid      out  1       one-cycle pulse per completed beat; no backpressure
// - rsp_rdata      out  DATA_W  read data; 0 on write responses
// - rsp_last       out  1       final beat of request, qualified by rsp_valid
// - rsp_err        out  1       verify mismatch (see CONFIGURATION), qualified by rsp_valid
// - busy           out  1       ~req_ready
// - rf_enable      out  1       memory enable strobe
// - rf_read_write  out  1       1 = write, 0 = read
// - rf_sel         out  ADDR_W  memory address
// - rf_data_in     out  DATA_W  memory write data
// - rf_data_out    in   DATA_W  memory read data
// BEHAVIOUR
// - Reset: all outputs 0 except req_ready = 1. State goes to IDLE. Counters and latched request are cleared.
// - Reset mid-operation: the request is aborted at that edge. No response is issued. rf_enable is low from the next cycle on.
// - FSM states: IDLE, WR, RD, WAIT, RESP.
//   - IDLE: req_ready = 1. Accept when req_valid && req_ready. Latch addr, len and wdata. Go to WR (write) or RD (read).
//   - WR: one cycle with rf_enable = 1, rf_read_write = 1, rf_sel = addr, rf_data_in = wdata. Go to RESP.
//   - RD: one cycle with rf_enable = 1, rf_read_write = 0, rf_sel = addr.
//     - RD_LAT = 0: capture rf_data_out in this cycle and go to RESP.
//     - RD_LAT > 0: go to WAIT.
//   - WAIT: count RD_LAT cycles. Capture rf_data_out in the last count cycle. Go to RESP.
//   - RESP: rsp_valid = 1 for one cycle. rsp_last = 1 when the beat counter is 0.
//     - If not last: addr <= addr + 1 with wrap (2**ADDR_W-1 -> 0), counter decrements, go to RD.
//     - If last: go to IDLE.
// - rf_enable is 0 in every state except WR and RD. rf_sel and rf_data_in hold their last values when idle.
// - Latency, with the accept edge in cycle N:
//   - write: strobe in N+1, rsp_valid in N+2.
//   - read beat: strobe in S, rsp_valid in S+RD_LAT+1.
//   - next beat strobe in S+RD_LAT+2.
// - A new request can be accepted in the cycle after the final RESP. There is no overlap or pipelining between requests.
// - req_len = 2**ADDR_W-1 reads the whole memory once, starting at req_addr and wrapping.
// - req_valid while busy is ignored and not queued. Requestor inputs are not sampled outside the IDLE accept.
// CONFIGURATION
// - Macro REG_PORT_MASTER_VERIFY_EN.
// - Defined: after the WR strobe the block enters VRD.
//   - VRD: rf_enable = 1, rf_read_write = 0, same rf_sel.
//   - Then WAIT, same RD_LAT rules as a read beat.
//   - Captured data is compared with the latched wdata. rsp_err = 1 on mismatch.
//   - Write response moves to N+3+RD_LAT.
//   - rsp_rdata carries the readback value.
// - Undefined: no VRD state. rsp_err is constant 0 and write latency is as above.
// TESTING
// 1. Apply rst for 2 cycles, then release.
//    -> req_ready = 1, rsp_valid = 0, rf_enable = 0, busy = 0.
// 2. Write addr 5, data 0xDEADBEEF.
//    -> exactly one rf_enable cycle with rf_read_write = 1, rf_sel = 5, rf_data_in = 0xDEADBEEF.
//    -> rsp_valid pulse 2 cycles after accept with rsp_last = 1.
// 3. Preload mem[i] = i*3. Read addr 30, len 3, RD_LAT = 1.
//    -> strobes at sel 30, 31, 0, 1.
//    -> rsp_rdata 90, 93, 0, 3.
//    -> rsp_last only on the 4th beat; beats spaced 3 cycles apart.
// 4. Hold req_valid high through a read burst with different req_addr.
//    -> second request accepted only after the final RESP; first burst unaffected.
// 5. Assert rst during WAIT of beat 2 of a len = 7 read.
//    -> no further rsp_valid; rf_enable = 0 from the next cycle; req_ready = 1 after reset.
// 6. With REG_PORT_MASTER_VERIFY_EN, write 0x12345678 to a model that corrupts bit 0.
//    -> rsp_err = 1, rsp_rdata = 0x12345679.
//    -> without the macro: rsp_err = 0.

Source files
------------

// File: rtl/reg_port_master.sv
// Request/response initiator that sequences single writes and burst reads onto the register-file control port.
// Optional write readback verification is compiled in with `define REG_PORT_MASTER_VERIFY_EN.
module reg_port_master #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [ADDR_W-1:0] req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              busy,
   output logic              rf_enable,
   output logic              rf_read_write,
   output logic [ADDR_W-1:0] rf_sel,
   output logic [DATA_W-1:0] rf_data_in,
   input  logic [DATA_W-1:0] rf_data_out
);

   localparam int WAIT_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WAIT,
      RESP
`ifdef REG_PORT_MASTER_VERIFY_EN
      , VRD
`endif
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              wr_q;
   logic [2:0]        wait_q;
   logic              capture;

   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      rf_enable     = 1'b0;
      rf_read_write = 1'b0;
      rsp_valid     = 1'b0;
      rsp_last      = 1'b0;
      capture       = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = req_write ? WR : RD;
         end
         WR: begin
            rf_enable     = 1'b1;
            rf_read_write = 1'b1;
`ifdef REG_PORT_MASTER_VERIFY_EN
            state_nxt     = VRD;
`else
            state_nxt     = RESP;
`endif
         end
         // A verify readback strobe behaves exactly like a read beat.
         RD
`ifdef REG_PORT_MASTER_VERIFY_EN
         , VRD
`endif
         : begin
            rf_enable = 1'b1;
            if (RD_LAT == 0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (wait_q == 3'd0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = (cnt_q == '0);
            state_nxt = (cnt_q == '0) ? IDLE : RD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         wait_q  <= '0;
      end else begin
         state <= state_nxt;
         // wdata is only taken on writes so rf_data_in keeps the last written word.
         if (state == IDLE && req_valid) begin
            addr_q <= req_addr;
            wr_q   <= req_write;
            cnt_q  <= req_write ? '0 : req_len;
            if (req_write) wdata_q <= req_wdata;
         end
         if (capture) rdata_q <= rf_data_out;
         if (state_nxt == WAIT && state != WAIT) wait_q <= 3'(WAIT_INIT);
         else if (state == WAIT)                 wait_q <= wait_q - 3'd1;
         if (state == RESP && cnt_q != '0) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
         end
      end
   end

   assign busy       = ~req_ready;
   assign rf_sel     = addr_q;
   assign rf_data_in = wdata_q;

`ifdef REG_PORT_MASTER_VERIFY_EN
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid && wr_q && (rdata_q != wdata_q);
`else
   assign rsp_rdata = (rsp_valid && !wr_q) ? rdata_q : '0;
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_port_master.sv
// Scoreboard bench for reg_port_master: driver pushes expected strobes/responses, monitor pops and compares.
module tb_reg_port_master;

   localparam int RD_LAT = 1;
   localparam int PIDX   = (RD_LAT > 0) ? RD_LAT - 1 : 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [4:0]  req_addr = '0;
   logic [4:0]  req_len = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_last;
   logic        rsp_err;
   logic        busy;
   logic        rf_enable;
   logic        rf_read_write;
   logic [4:0]  rf_sel;
   logic [31:0] rf_data_in;
   logic [31:0] rf_data_out;

   reg_port_master #(.DATA_W(32), .ADDR_W(5), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .busy(busy), .rf_enable(rf_enable), .rf_read_write(rf_read_write),
      .rf_sel(rf_sel), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
   );

   always #5 clk = ~clk;

   // Memory model; 'corrupt' flips bit 0 of stored write data.
   bit          corrupt = 1'b0;
   logic [31:0] mem [0:31];
   logic [31:0] rd_pipe [0:7];

   always @(posedge clk) begin
      if (rf_enable && rf_read_write) mem[rf_sel] <= corrupt ? (rf_data_in ^ 32'd1) : rf_data_in;
      rd_pipe[0] <= mem[rf_sel];
      for (int k = 1; k < 8; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign rf_data_out = (RD_LAT == 0) ? mem[rf_sel] : rd_pipe[PIDX];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [31:0] rdata; logic last; logic err; } rsp_t;
   typedef struct { int cyc; logic [4:0] sel; logic rw; logic [31:0] data; } stb_t;

   rsp_t        rsp_q [$];
   stb_t        stb_q [$];
   logic [31:0] ref_mem [0:31];
   int          tests = 0;
   int          fails = 0;
   int          next_free = 0;
   int          last_accept = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      stb_t s;
      rsp_t r;
      if (!rst) begin
         if (rf_enable) begin
            if (stb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_strobe: got rf_enable=1 expected 0 (cycle %0d)", cyc);
            end else begin
               s = stb_q.pop_front();
               chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
               chk("strobe_sel", 64'(rf_sel), 64'(s.sel));
               chk("strobe_rw", 64'(rf_read_write), 64'(s.rw));
               if (s.rw) chk("strobe_wdata", 64'(rf_data_in), 64'(s.data));
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
               chk("rsp_last", 64'(rsp_last), 64'(r.last));
               chk("rsp_err", 64'(rsp_err), 64'(r.err));
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic w, input logic [4:0] a, input logic [4:0] len,
                        input logic [31:0] d, input bit hold);
      int   c0, n, guard, exp_n, len_i;
      logic [4:0] ai;
      rsp_t r;
      stb_t s;
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = len; req_wdata = d;
      c0 = cyc;
      guard = 0;
      while (!req_ready && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
         req_valid = 1'b0;
         return;
      end
      n = cyc;
      exp_n = (c0 > next_free) ? c0 : next_free;
      chk("accept_cycle", 64'(n), 64'(exp_n));
      last_accept = n;
      if (w) begin
         ref_mem[a] = corrupt ? (d ^ 32'd1) : d;
         s.cyc = n + 1; s.sel = a; s.rw = 1'b1; s.data = d;
         stb_q.push_back(s);
`ifdef REG_PORT_MASTER_VERIFY_EN
         s.cyc = n + 2; s.rw = 1'b0;
         stb_q.push_back(s);
         r.cyc = n + 3 + RD_LAT; r.rdata = ref_mem[a]; r.err = corrupt;
`else
         r.cyc = n + 2; r.rdata = '0; r.err = 1'b0;
`endif
         r.last = 1'b1;
         rsp_q.push_back(r);
      end else begin
         len_i = int'(len);
         for (int i = 0; i <= len_i; i++) begin
            ai = a + 5'(i);
            s.cyc = n + 1 + i * (RD_LAT + 2); s.sel = ai; s.rw = 1'b0; s.data = '0;
            stb_q.push_back(s);
            r.cyc = s.cyc + RD_LAT + 1; r.rdata = ref_mem[ai]; r.last = (i == len_i); r.err = 1'b0;
            rsp_q.push_back(r);
         end
      end
      next_free = r.cyc + 1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((rsp_q.size() != 0 || stb_q.size() != 0) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk("queue_drained", 64'(rsp_q.size() + stb_q.size()), 64'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rf_enable"}, 64'(rf_enable), 64'd0);
      chk({tag, "_rf_sel"}, 64'(rf_sel), 64'd0);
      chk({tag, "_rf_data_in"}, 64'(rf_data_in), 64'd0);
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
   endtask

   initial begin
      int gap, target;
      bit w, hold;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state("reset");

      issue(1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0);
      drain();

      for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 5'd0, 32'(i * 3), 1'b0);
      drain();

      // Wrapping burst: sel 30,31,0,1 -> 90,93,0,3
      issue(1'b0, 5'd30, 5'd3, 32'd0, 1'b0);
      drain();

      // Second request held during the first burst, with a different address.
      issue(1'b0, 5'd2, 5'd2, 32'd0, 1'b1);
      issue(1'b0, 5'd20, 5'd1, 32'd0, 1'b0);
      drain();

      // Reset in the WAIT of beat 2 of an 8-beat read.
      issue(1'b0, 5'd10, 5'd7, 32'd0, 1'b0);
      target = last_accept + 1 + (RD_LAT + 2) + 1;
      while (cyc < target) @(negedge clk);
      rst = 1'b1;
      rsp_q.delete();
      stb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      next_free = 0;
      chk_reset_state("midreset");
      repeat (20) @(negedge clk);
      chk("midreset_idle_ready", 64'(req_ready), 64'd1);

      // Memory was reset-agnostic; restore a known image after the abort.
      for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 5'd0, 32'(i * 3), 1'b0);
      drain();

      corrupt = 1'b1;
      issue(1'b1, 5'd7, 5'd0, 32'h12345678, 1'b0);
      drain();
      corrupt = 1'b0;

      issue(1'b1, 5'd31, 5'd0, 32'hA5A5_0001, 1'b0);
      issue(1'b0, 5'd31, 5'd31, 32'd0, 1'b0);
      drain();

      for (int t = 0; t < 40; t++) begin
         gap  = int'($urandom_range(0, 2));
         w    = 1'($urandom_range(0, 1));
         hold = (gap == 0) && ($urandom_range(0, 1) == 1);
         issue(w, 5'($urandom_range(0, 31)),
               ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
               $urandom, hold);
         repeat (gap) @(negedge clk);
      end
      req_valid = 1'b0;
      drain();
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule
